// File: rtl/mhd_err_monitor.sv
// mhd_err_monitor: two-stage Hamming-distance error monitor with running statistics.
// Ports:
//   clk, rst        clock and asynchronous active-high reset
//   clr             synchronous clear of the statistics (pipeline untouched)
//   in_valid/ready  input handshake for the operand pair a (exact) / b (approx)
//   out_valid/ready output handshake for the per-sample result hd / viol
//   samp_cnt        samples counted, viol_cnt violations counted (both saturating)
//   max_hd          largest distance counted
//   first_idx/vld   sample index of the first violation and its valid flag
//   sat             sticky: a counter has reached all-ones
module mhd_err_monitor #(
    parameter int WIDTH = 8,
    parameter int MHD   = 2,
    parameter int CNT_W = 16,
    localparam int HW   = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [HW-1:0]    hd,
    output logic             viol,
    output logic [CNT_W-1:0] samp_cnt,
    output logic [CNT_W-1:0] viol_cnt,
    output logic [HW-1:0]    max_hd,
    output logic [CNT_W-1:0] first_idx,
    output logic             first_vld,
    output logic             sat
);
    logic [WIDTH-1:0] x1;
    logic             v1;
    logic [HW-1:0]    pc;
    logic             pv;
    logic             adv;
    logic             ev;
    logic [CNT_W-1:0] samp_inc;
    logic [CNT_W-1:0] viol_nxt;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    // a count event is a valid stage-1 entry moving into stage 2
    assign ev       = adv && v1;

    always_comb begin
        pc = '0;
        for (int i = 0; i < WIDTH; i++) pc = pc + HW'(x1[i]);
    end

    assign pv       = int'(pc) > MHD;
    assign samp_inc = samp_cnt + CNT_W'(!(&samp_cnt));
    assign viol_nxt = pv ? viol_cnt + CNT_W'(!(&viol_cnt)) : viol_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x1        <= '0;
            v1        <= 1'b0;
            out_valid <= 1'b0;
            hd        <= '0;
            viol      <= 1'b0;
        end else if (adv) begin
            x1        <= a ^ b;
            v1        <= in_valid;
            out_valid <= v1;
            hd        <= pc;
            viol      <= pv;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst || clr) begin
            samp_cnt  <= '0;
            viol_cnt  <= '0;
            max_hd    <= '0;
            first_idx <= '0;
            first_vld <= 1'b0;
            sat       <= 1'b0;
        end else if (ev) begin
            samp_cnt  <= samp_inc;
            viol_cnt  <= viol_nxt;
            max_hd    <= pc > max_hd ? pc : max_hd;
            // the index recorded is the pre-increment sample count
            first_idx <= pv && !first_vld ? samp_cnt : first_idx;
            first_vld <= first_vld || pv;
            sat       <= sat || (&samp_inc) || (&viol_nxt);
        end
    end
endmodule

// File: tb/tb_mhd_err_monitor.sv
// tb_mhd_err_monitor: directed and randomized self-checking bench for mhd_err_monitor.
module tb_mhd_err_monitor;
    logic        clk = 0;
    logic        rst = 1;
    logic        clr = 0;
    logic        in_valid = 0;
    logic        in_ready;
    logic [7:0]  a = 0;
    logic [7:0]  b = 0;
    logic        out_valid;
    logic        out_ready = 1;
    logic [3:0]  hd;
    logic        viol;
    logic [15:0] samp_cnt;
    logic [15:0] viol_cnt;
    logic [3:0]  max_hd;
    logic [15:0] first_idx;
    logic        first_vld;
    logic        sat;

    logic        s_in_valid = 0;
    logic        s_in_ready;
    logic [7:0]  s_a = 0;
    logic [7:0]  s_b = 0;
    logic        s_out_valid;
    logic [3:0]  s_hd;
    logic        s_viol;
    logic [3:0]  s_samp_cnt;
    logic [3:0]  s_viol_cnt;
    logic [3:0]  s_max_hd;
    logic [3:0]  s_first_idx;
    logic        s_first_vld;
    logic        s_sat;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mhd_err_monitor dut (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .hd(hd), .viol(viol),
        .samp_cnt(samp_cnt), .viol_cnt(viol_cnt), .max_hd(max_hd), .first_idx(first_idx),
        .first_vld(first_vld), .sat(sat)
    );

    mhd_err_monitor #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .clr(1'b0), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .a(s_a), .b(s_b), .out_valid(s_out_valid), .out_ready(1'b1), .hd(s_hd), .viol(s_viol),
        .samp_cnt(s_samp_cnt), .viol_cnt(s_viol_cnt), .max_hd(s_max_hd), .first_idx(s_first_idx),
        .first_vld(s_first_vld), .sat(s_sat)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_stats_zero(input string tag);
        chk({tag, "_samp"}, samp_cnt, 0);
        chk({tag, "_viol"}, viol_cnt, 0);
        chk({tag, "_max"}, max_hd, 0);
        chk({tag, "_fidx"}, first_idx, 0);
        chk({tag, "_fvld"}, first_vld, 0);
        chk({tag, "_sat"}, sat, 0);
    endtask

    logic [7:0] sa [4] = '{8'h00, 8'h0F, 8'hFF, 8'h01};
    logic [7:0] sb [4] = '{8'h00, 8'h0C, 8'h00, 8'h07};
    int         shd [4] = '{0, 2, 8, 2};
    int         sv  [4] = '{0, 0, 1, 0};
    logic [7:0] bp_b [4] = '{8'h01, 8'h03, 8'h07, 8'h0F};

    int exp_q [$];
    int m_samp;
    int m_viol;
    int e;
    int mode;

    initial begin
        tick;
        tick;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_hd", hd, 0);
        chk("rst_viol", viol, 0);
        chk("rst_in_ready", in_ready, 1);
        chk_stats_zero("rst");
        @(negedge clk);
        rst = 0;
        tick;

        for (int n = 0; n < 6; n++) begin
            if (n >= 2) begin
                chk("str_ov", out_valid, 1);
                chk("str_hd", hd, shd[n-2]);
                chk("str_viol", viol, sv[n-2]);
            end
            in_valid = n < 4;
            if (n < 4) begin
                a = sa[n];
                b = sb[n];
            end
            tick;
        end
        chk("str_samp", samp_cnt, 4);
        chk("str_vcnt", viol_cnt, 1);
        chk("str_max", max_hd, 8);
        chk("str_fidx", first_idx, 2);
        chk("str_fvld", first_vld, 1);

        clr = 1;
        tick;
        clr = 0;
        chk_stats_zero("clr0");
        a = 0;
        for (int n = 0; n < 3; n++) begin
            in_valid = 1;
            b = bp_b[n];
            tick;
        end
        out_ready = 0;
        b = bp_b[3];
        #1;
        for (int n = 0; n < 5; n++) begin
            chk("bp_in_ready", in_ready, 0);
            chk("bp_ov", out_valid, 1);
            chk("bp_hd", hd, 2);
            chk("bp_viol", viol, 0);
            chk("bp_samp", samp_cnt, 2);
            tick;
        end
        out_ready = 1;
        #1;
        chk("bp_resume_ready", in_ready, 1);
        tick;
        in_valid = 0;
        chk("bp_hd_p2", hd, 3);
        chk("bp_viol_p2", viol, 1);
        tick;
        chk("bp_hd_p3", hd, 4);
        chk("bp_ov_p3", out_valid, 1);
        tick;
        chk("bp_drain_ov", out_valid, 0);
        chk("bp_samp_end", samp_cnt, 4);
        chk("bp_vcnt_end", viol_cnt, 2);

        in_valid = 1;
        a = 8'hFF;
        b = 8'h00;
        tick;
        in_valid = 0;
        clr = 1;
        tick;
        clr = 0;
        chk_stats_zero("clr_ev");
        chk("clr_ov", out_valid, 1);
        chk("clr_hd", hd, 8);
        chk("clr_viol", viol, 1);
        tick;

        s_a = 8'hFF;
        s_b = 8'h00;
        for (int n = 0; n < 22; n++) begin
            if (n == 15) begin
                chk("sat_samp14", s_samp_cnt, 14);
                chk("sat_pre", s_sat, 0);
            end
            if (n == 16) chk("sat_set", s_sat, 1);
            s_in_valid = n < 20;
            tick;
        end
        chk("sat_samp", s_samp_cnt, 15);
        chk("sat_vcnt", s_viol_cnt, 15);
        chk("sat_flag", s_sat, 1);
        chk("sat_fidx", s_first_idx, 0);
        chk("sat_fvld", s_first_vld, 1);

        a = 8'h00;
        b = 8'h03;
        in_valid = 1;
        tick;
        b = 8'h3F;
        tick;
        in_valid = 0;
        #3;
        rst = 1;
        #1;
        chk("mrst_ov", out_valid, 0);
        chk("mrst_hd", hd, 0);
        chk_stats_zero("mrst");
        @(negedge clk);
        rst = 0;
        #1;
        chk("mrst_in_ready", in_ready, 1);
        in_valid = 1;
        b = 8'h01;
        tick;
        in_valid = 0;
        tick;
        chk("mrst_samp1", samp_cnt, 1);
        chk("mrst_ov1", out_valid, 1);
        tick;
        tick;

        clr = 1;
        tick;
        clr = 0;
        m_samp = 0;
        m_viol = 0;
        for (int n = 0; n < 10000; n++) begin
            mode = $urandom_range(0, 7);
            a = 8'($urandom);
            b = mode == 0 ? a : mode == 1 ? ~a : 8'($urandom);
            in_valid = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 3) != 0;
            #1;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("rnd_underflow", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("rnd_hd", hd, e);
                end
            end
            if (in_valid && in_ready) begin
                e = $countones(a ^ b);
                exp_q.push_back(e);
                m_samp++;
                if (e > 2) m_viol++;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 0;
        out_ready = 1;
        for (int n = 0; n < 10; n++) begin
            #1;
            if (out_valid) begin
                if (exp_q.size() == 0) chk("rnd_underflow", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("rnd_hd_drain", hd, e);
                end
            end
            @(posedge clk);
            #1;
        end
        chk("rnd_left", exp_q.size(), 0);
        chk("rnd_samp", samp_cnt, m_samp);
        chk("rnd_vcnt", viol_cnt, m_viol);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mhd_err_monitor.md
MHD_ERR_MONITOR -- requirements
Module: mhd_err_monitor

Interface
REQ-001 SHALL have parameter WIDTH, default 8: width of each compared operand.
REQ-002 SHALL have parameter MHD, default 2: maximum tolerated Hamming distance; a sample whose distance exceeds MHD is a violation.
REQ-003 SHALL have parameter CNT_W, default 16: width of the statistic counters.
REQ-004 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-006 SHALL have port clr, input, 1: synchronous clear of the statistics only.
REQ-007 SHALL have port in_valid, input, 1: an operand pair is presented.
REQ-008 SHALL have port in_ready, output, 1: the block accepts the pair this cycle.
REQ-009 SHALL have port a, input, WIDTH: exact-circuit output word.
REQ-010 SHALL have port b, input, WIDTH: approximate-circuit output word.
REQ-011 SHALL have port out_valid, output, 1: a per-sample result is held.
REQ-012 SHALL have port out_ready, input, 1: the consumer takes the result.
REQ-013 SHALL have port hd, output, 4: Hamming distance of the held sample (sized for WIDTH=8; for other WIDTH, clog2(WIDTH+1)).
REQ-014 SHALL have port viol, output, 1: the held sample has hd > MHD.
REQ-015 SHALL have port samp_cnt, output, CNT_W: number of samples counted.
REQ-016 SHALL have port viol_cnt, output, CNT_W: number of violating samples counted.
REQ-017 SHALL have port max_hd, output, 4: largest hd counted.
REQ-018 SHALL have port first_idx, output, CNT_W: samp_cnt value of the first violation.
REQ-019 SHALL have port first_vld, output, 1: first_idx is valid.
REQ-020 SHALL have port sat, output, 1: sticky flag, set when any counter is saturated.

Function
REQ-021 SHALL be a two-stage pipeline. Stage 1 registers a^b and a valid bit. Stage 2 registers the popcount (hd), viol, and a valid bit (out_valid).
REQ-022 SHALL compute advance = !out_valid || out_ready, and drive in_ready = advance combinationally.
REQ-023 SHALL, when advance=1, load stage 1 from the inputs (valid = in_valid) and load stage 2 from stage 1 on the same edge. When advance=0, both stages SHALL hold.
REQ-024 SHALL give a latency of exactly 2 cycles from an accepted input to out_valid when out_ready is held high. The pipeline SHALL sustain 1 sample per cycle.
REQ-025 SHALL update the statistics on the edge where a valid stage-1 entry moves into stage 2 ("count event"), and only then.
REQ-026 SHALL, on a count event, apply the following updates:
- samp_cnt increments.
- viol_cnt increments if viol.
- max_hd = max(max_hd, hd).
REQ-027 SHALL, on a count event that is a violation while first_vld=0, load first_idx with the pre-increment samp_cnt and set first_vld.
REQ-028 SHALL saturate samp_cnt and viol_cnt at all-ones (no wrap). sat SHALL be set when either counter reaches all-ones and SHALL hold until clr or rst.
REQ-029 SHALL, on clr=1, zero the following on the next edge: samp_cnt, viol_cnt, max_hd, first_idx, first_vld, sat. clr SHALL have priority over a coincident count event; that sample is not counted but still flows to the output.
REQ-030 SHALL leave pipeline contents and the handshake unaffected by clr.
REQ-031 SHALL keep hd and viol stable while out_valid=1 and out_ready=0.
REQ-032 SHALL produce hd=0, viol=0 for a==b, and hd=WIDTH, viol=1 for a==~b.

Reset
REQ-033 SHALL, while rst=1, asynchronously force the following to 0: both stage valid bits, out_valid, hd, viol, samp_cnt, viol_cnt, max_hd, first_idx, first_vld, sat.
REQ-034 SHALL, when rst asserts mid-stream, discard any in-flight samples without counting them. in_ready SHALL be 1 in the first cycle after release.

Verification
REQ-035 SHALL cover streaming: out_ready=1; pairs (0x00,0x00), (0x0F,0x0C), (0xFF,0x00), (0x01,0x07), one per cycle. Required: hd = 0, 2, 8, 2 appear 2 cycles after each; viol = 0, 0, 1, 0; then samp_cnt=4, viol_cnt=1, max_hd=8, first_idx=2, first_vld=1.
REQ-036 SHALL cover back-pressure: two valid pairs in flight, out_ready=0 for 5 cycles. Required: in_ready=0, hd/viol held, samp_cnt frozen at 2; on out_ready=1 the stream resumes with no loss or duplication.
REQ-037 SHALL cover clr: clr pulses on the same edge as a violating count event. Required: all stats read 0 the next cycle; that sample's out_valid/hd/viol still delivered.
REQ-038 SHALL cover saturation: CNT_W=4 and 20 violating samples. Required: samp_cnt=viol_cnt=15, sat=1, first_idx=0.
REQ-039 SHALL cover reset mid-stream: rst asserted with both stages valid. Required: out_valid=0 immediately, all stats 0; after release, the first new sample gives samp_cnt=1.
REQ-040 SHALL cover a randomized check: 10k random (a,b) pairs with random in_valid/out_ready. Required: every hd equals popcount(a^b) in order; viol_cnt equals the model count of hd>2.
